// File: rtl/hazard_pipe_regs_pkg.sv
// Shared core types: pipeline control fields and per-stage register layouts.
// The architectural NOP (addi x0,x0,0) is the instruction a squashed IF/DE stage holds.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 reg_write;
    logic                 load;
    logic                 store;
  } ctrl_t;

  typedef struct packed {
    logic  valid;
    ctrl_t ctrl;
  } stage_t;

  // Downstream stages keep only the fields the hazard unit still consumes.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 load;
  } ex_mem_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
  } mem_wb_t;

  function automatic logic [REG_IDX_W-1:0] gate_idx(input logic valid,
                                                    input logic [REG_IDX_W-1:0] idx);
    return valid ? idx : '0;
  endfunction

endpackage

// File: rtl/hazard_pipe_regs_if.sv
// Bundle between the hazard unit / decode stage (master) and the pipeline register bank (slave).
interface hazard_pipe_regs_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             flush_if_de;
  logic             flush_de_ex;
  logic [XLEN-1:0]  if_pc;
  logic [31:0]      if_ir;
  logic [4:0]       de_rd_in;
  logic [4:0]       de_rs1_in;
  logic [4:0]       de_rs2_in;
  logic             de_reg_write_in;
  logic             de_load_in;
  logic             de_store_in;

  logic             pc_en;
  logic [XLEN-1:0]  de_pc;
  logic [31:0]      de_ir;
  logic [4:0]       de_ex_rd;
  logic [4:0]       de_ex_rs1;
  logic [4:0]       de_ex_rs2;
  logic             de_rd_reg_write;
  logic             de_ex_load;
  logic             de_ex_store;
  logic [4:0]       ex_rd;
  logic             ex_rd_reg_write;
  logic             ex_load;
  logic [4:0]       mem_rd;
  logic             mem_rd_reg_write;
  logic             de_ex_stalled;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output stall, flush_if_de, flush_de_ex, if_pc, if_ir,
           de_rd_in, de_rs1_in, de_rs2_in, de_reg_write_in, de_load_in, de_store_in,
    input  pc_en, de_pc, de_ir, de_ex_rd, de_ex_rs1, de_ex_rs2,
           de_rd_reg_write, de_ex_load, de_ex_store,
           ex_rd, ex_rd_reg_write, ex_load, mem_rd, mem_rd_reg_write,
           de_ex_stalled, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, flush_if_de, flush_de_ex, if_pc, if_ir,
           de_rd_in, de_rs1_in, de_rs2_in, de_reg_write_in, de_load_in, de_store_in,
    output pc_en, de_pc, de_ir, de_ex_rd, de_ex_rs1, de_ex_rs2,
           de_rd_reg_write, de_ex_load, de_ex_store,
           ex_rd, ex_rd_reg_write, ex_load, mem_rd, mem_rd_reg_write,
           de_ex_stalled, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_pipe_regs_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so long debug runs stay readable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_pipe_regs.sv
// IF/DE, DE/EX, EX/MEM and MEM/WB control-path registers with stall/flush bubble insertion.
// Every control output is masked by its stage valid so a bubble can never write back, load or store.
module hazard_pipe_regs
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic               CLK,
  input logic               RST_N,
  hazard_pipe_regs_if.slave bus
);

  logic            if_de_valid_reg;
  logic [XLEN-1:0] de_pc_reg;
  logic [31:0]     de_ir_reg;
  stage_t          de_ex_reg;
  ex_mem_t         ex_mem_reg;
  mem_wb_t         mem_wb_reg;
  logic            de_ex_stalled_reg;
  ctrl_t           de_ctrl_next;

  assign de_ctrl_next = '{
    rd:        bus.de_rd_in,
    rs1:       bus.de_rs1_in,
    rs2:       bus.de_rs2_in,
    reg_write: bus.de_reg_write_in,
    load:      bus.de_load_in,
    store:     bus.de_store_in
  };

  // IF/DE: flush beats stall, so a squashed slot becomes a NOP even while the front end is frozen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      if_de_valid_reg <= 1'b0;
      de_pc_reg       <= '0;
      de_ir_reg       <= NOP_INSTR;
    end else if (bus.flush_if_de) begin
      if_de_valid_reg <= 1'b0;
      de_ir_reg       <= NOP_INSTR;
    end else if (!bus.stall) begin
      if_de_valid_reg <= 1'b1;
      de_pc_reg       <= bus.if_pc;
      de_ir_reg       <= bus.if_ir;
    end
  end

  // DE/EX: a bubble only drops valid; stale fields are harmless because outputs are gated.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      de_ex_reg         <= '0;
      de_ex_stalled_reg <= 1'b0;
    end else begin
      if (bus.flush_de_ex || bus.stall) begin
        de_ex_reg.valid <= 1'b0;
      end else begin
        de_ex_reg.valid <= if_de_valid_reg;
        de_ex_reg.ctrl  <= de_ctrl_next;
      end
      de_ex_stalled_reg <= bus.stall && !bus.flush_de_ex;
    end
  end

  // EX/MEM and MEM/WB never freeze: the load ahead of a load-use stall must still drain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_mem_reg <= '0;
      mem_wb_reg <= '0;
    end else begin
      ex_mem_reg <= '{
        valid:     de_ex_reg.valid,
        rd:        de_ex_reg.ctrl.rd,
        reg_write: de_ex_reg.ctrl.reg_write,
        load:      de_ex_reg.ctrl.load
      };
      mem_wb_reg <= '{
        valid:     ex_mem_reg.valid,
        rd:        ex_mem_reg.rd,
        reg_write: ex_mem_reg.reg_write
      };
    end
  end

  logic [1:0]       evt_inc;
  logic [CNT_W-1:0] evt_cnt [2];

  // A cycle flushing both stages is one flush event.
  assign evt_inc[0] = bus.stall;
  assign evt_inc[1] = bus.flush_if_de || bus.flush_de_ex;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_evt_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (evt_inc[gi]),
        .count (evt_cnt[gi])
      );
    end
  endgenerate

  assign bus.pc_en            = !bus.stall;
  assign bus.de_pc            = de_pc_reg;
  assign bus.de_ir            = de_ir_reg;

  assign bus.de_ex_rd         = de_ex_reg.ctrl.rd;
  assign bus.de_ex_rs1        = de_ex_reg.ctrl.rs1;
  assign bus.de_ex_rs2        = de_ex_reg.ctrl.rs2;
  assign bus.de_rd_reg_write  = de_ex_reg.valid && de_ex_reg.ctrl.reg_write;
  assign bus.de_ex_load       = de_ex_reg.valid && de_ex_reg.ctrl.load;
  assign bus.de_ex_store      = de_ex_reg.valid && de_ex_reg.ctrl.store;

  assign bus.ex_rd            = gate_idx(ex_mem_reg.valid, ex_mem_reg.rd);
  assign bus.ex_rd_reg_write  = ex_mem_reg.valid && ex_mem_reg.reg_write;
  assign bus.ex_load          = ex_mem_reg.valid && ex_mem_reg.load;

  assign bus.mem_rd           = gate_idx(mem_wb_reg.valid, mem_wb_reg.rd);
  assign bus.mem_rd_reg_write = mem_wb_reg.valid && mem_wb_reg.reg_write;

  assign bus.de_ex_stalled    = de_ex_stalled_reg;
  assign bus.stall_cnt        = evt_cnt[0];
  assign bus.flush_cnt        = evt_cnt[1];

endmodule
